// File: rtl/pbus_pkg.sv
// Shared PBus master definitions: FSM state encoding and default bus widths.
package pbus_pkg;

    localparam int PBUS_ADDR_W = 8;
    localparam int PBUS_DATA_W = 32;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        IDLE     = 3'd1,
        SETUP    = 3'd2,
        STROBE   = 3'd3,
        RECOVER  = 3'd4
    } PbusState;

endpackage

// File: rtl/pbus_if.sv
// PBus bundle: host request/response port plus the PBus pins seen by the master.
interface pbus_if
    import pbus_pkg::*;
#(
    parameter int ADDR_W = PBUS_ADDR_W,
    parameter int DATA_W = PBUS_DATA_W
) ();

    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic [ADDR_W-1:0] ReqAddr;
    logic [DATA_W-1:0] ReqWData;
    logic              RspValid;
    logic [DATA_W-1:0] RspRData;
    logic              RspErr;
    logic              PBusResetN;
    logic [ADDR_W-1:0] PBusAddr;
    logic [DATA_W-1:0] PBusDataOut;
    logic              PBusDataOE;
    logic [DATA_W-1:0] PBusDataIn;
    logic              PBusRDN;
    logic              PBusWRN;
    logic              PBusReadyN;

    modport master (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, PBusDataIn, PBusReadyN,
        output ReqReady, RspValid, RspRData, RspErr,
        output PBusResetN, PBusAddr, PBusDataOut, PBusDataOE, PBusRDN, PBusWRN
    );

    // Everything on the far side: the host driving requests and the PBus slave.
    modport slave (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, PBusDataIn, PBusReadyN,
        input  ReqReady, RspValid, RspRData, RspErr,
        input  PBusResetN, PBusAddr, PBusDataOut, PBusDataOE, PBusRDN, PBusWRN
    );

endinterface

// File: rtl/pbus_reset_hold.sv
// Holds the slave reset (active-low) for RESET_HOLD clocks after Reset falls.
module pbus_reset_hold #(
    parameter int RESET_HOLD = 4
) (
    input  logic Clk,
    input  logic Reset,
    output logic PBusResetN,
    output logic holdDone
);

    localparam int CntW = $clog2(RESET_HOLD + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(RESET_HOLD - 1);

    logic [CntW-1:0] cntReg;
    logic            doneReg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cntReg  <= '0;
            doneReg <= 1'b0;
        end else if (!doneReg) begin
            if (cntReg == CntLast) begin
                doneReg <= 1'b1;
            end else begin
                cntReg <= cntReg + 1'b1;
            end
        end
    end

    assign PBusResetN = doneReg;
    assign holdDone   = doneReg;

endmodule

// File: rtl/pbus_master.sv
// PBus initiator: converts request/response handshakes into registered RDN/WRN strobes.
// Optional macro PBUS_TIMEOUT_EN aborts a strobe after TIMEOUT cycles without ready.
module pbus_master
    import pbus_pkg::*;
#(
    parameter int ADDR_W       = PBUS_ADDR_W,
    parameter int DATA_W       = PBUS_DATA_W,
    parameter int SETUP_CYCLES = 1,
    parameter int RESET_HOLD   = 4,
    parameter int TIMEOUT      = 64
) (
    input logic    Clk,
    input logic    Reset,
    pbus_if.master bus
);

    if (RESET_HOLD < 1 || SETUP_CYCLES < 0 || SETUP_CYCLES > 15 || TIMEOUT < 1) begin : gParamCheck
        $error("pbus_master: parameter out of range");
    end

    localparam logic [3:0] SetupLast = 4'(SETUP_CYCLES - 1);

    PbusState          stateReg, stateNext;
    logic [3:0]        setupCntReg;
    logic              writeReg;
    logic              writeNext;
    logic              accept;
    logic              holdDone;
    logic              timeoutHit;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] dataOutReg;
    logic [DATA_W-1:0] rdataReg;
    logic              rdnReg;
    logic              wrnReg;
    logic              oeReg;

    pbus_reset_hold #(
        .RESET_HOLD (RESET_HOLD)
    ) uResetHold (
        .Clk        (Clk),
        .Reset      (Reset),
        .PBusResetN (bus.PBusResetN),
        .holdDone   (holdDone)
    );

`ifdef PBUS_TIMEOUT_EN
    localparam int TimeoutW = $clog2(TIMEOUT + 1);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT - 1);

    logic [TimeoutW-1:0] timeoutCntReg;
    logic                errReg;

    assign timeoutHit = (stateReg == STROBE) && (timeoutCntReg == TimeoutLast);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            timeoutCntReg <= '0;
        end else if (stateReg == STROBE) begin
            timeoutCntReg <= timeoutCntReg + 1'b1;
        end else begin
            timeoutCntReg <= '0;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    assign accept    = (stateReg == IDLE) && bus.ReqValid;
    assign writeNext = accept ? bus.ReqWrite : writeReg;

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            RST_HOLD: if (holdDone) stateNext = IDLE;
            IDLE:     if (bus.ReqValid) stateNext = (SETUP_CYCLES == 0) ? STROBE : SETUP;
            SETUP:    if (setupCntReg == SetupLast) stateNext = STROBE;
            STROBE:   if (!bus.PBusReadyN || timeoutHit) stateNext = RECOVER;
            RECOVER:  stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // Strobes and OE are decoded from the next state so they switch on the same edge as the FSM.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stateReg    <= RST_HOLD;
            setupCntReg <= '0;
            writeReg    <= 1'b0;
            addrReg     <= '0;
            dataOutReg  <= '0;
            rdataReg    <= '0;
            rdnReg      <= 1'b1;
            wrnReg      <= 1'b1;
            oeReg       <= 1'b0;
`ifdef PBUS_TIMEOUT_EN
            errReg      <= 1'b0;
`endif
        end else begin
            stateReg    <= stateNext;
            setupCntReg <= (stateReg == SETUP) ? setupCntReg + 1'b1 : 4'd0;
            rdnReg      <= !((stateNext == STROBE) && !writeNext);
            wrnReg      <= !((stateNext == STROBE) && writeNext);
            oeReg       <= writeNext && (stateNext inside {SETUP, STROBE, RECOVER});
            if (accept) begin
                writeReg   <= bus.ReqWrite;
                addrReg    <= bus.ReqAddr;
                dataOutReg <= bus.ReqWData;
`ifdef PBUS_TIMEOUT_EN
                errReg     <= 1'b0;
`endif
            end
            if ((stateReg == STROBE) && !bus.PBusReadyN && !writeReg) begin
                rdataReg <= bus.PBusDataIn;
            end
`ifdef PBUS_TIMEOUT_EN
            // Ready on the final strobe cycle still wins over the abort.
            if (timeoutHit && bus.PBusReadyN) begin
                errReg   <= 1'b1;
                rdataReg <= '0;
            end
`endif
        end
    end

    assign bus.ReqReady    = (stateReg == IDLE);
    assign bus.RspValid    = (stateReg == RECOVER);
    assign bus.RspRData    = rdataReg;
`ifdef PBUS_TIMEOUT_EN
    assign bus.RspErr      = errReg;
`else
    assign bus.RspErr      = 1'b0;
`endif
    assign bus.PBusAddr    = addrReg;
    assign bus.PBusDataOut = dataOutReg;
    assign bus.PBusDataOE  = oeReg;
    assign bus.PBusRDN     = rdnReg;
    assign bus.PBusWRN     = wrnReg;

endmodule
